firing_controller: RTL and testbench

Control-side counterpart of the firing datapath. Conditions the player's trigger and reload buttons and sequences them into the 3-bit firing control code that the datapath consumes. It enforces cooldown between shots, timed reloads and dry-fire detection. It sits between the board button inputs and the firing datapath, and reads the datapath's remaining-shot count back as status.

---
 rtl/firing_pkg.sv | 24 ++
 rtl/button_conditioner.sv | 73 +++++++
 rtl/firing_controller.sv | 126 ++++++++++++
 tb/tb_firing_controller.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/firing_pkg.sv
// Shared definitions for the firing controller and the firing datapath:
// control codes, FSM state encoding and the magazine size.
package firing_pkg;

  localparam logic [2:0] CTRL_RELOAD = 3'b000;
  localparam logic [2:0] CTRL_HOLD   = 3'b001;
  localparam logic [2:0] CTRL_SHOT   = 3'b011;

  localparam logic [1:0] MAX_SHOTS   = 2'b11;

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_FIRE   = 2'd1,
    S_COOL   = 2'd2,
    S_RELOAD = 2'd3
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw button -> 2-flop synchronizer -> optional debounce filter -> one-cycle
// press strobe on the rising edge. Debounce is compiled in by FIRING_DEBOUNCE_EN.
module button_conditioner
`ifdef FIRING_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYCLES = 16)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic level;

  always_comb begin
    meta_d = btn;
    sync_d = meta_q;
    prev_d = level;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain a chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

`ifdef FIRING_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The filtered level follows the synchronized input only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) filt_d = sync_q;
      else                                      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q;
`endif

  assign press = level & ~prev_q;

endmodule

// File: rtl/firing_controller.sv
// Trigger/reload sequencer producing the firing control code for the datapath,
// with cooldown, timed reload and dry-fire detection. Optional: FIRING_DEBOUNCE_EN.
module firing_controller
  import firing_pkg::*;
#(
  parameter int COOLDOWN_CYCLES = 4,
  parameter int RELOAD_CYCLES   = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire_btn,
  input  logic       reload_btn,
  input  logic       round_active,
  input  logic [1:0] remaining_shots,
  output logic [2:0] control,
  output logic       shot_fired,
  output logic       dry_fire,
  output logic       reloading
);

  localparam int TIMER_W =
    $clog2(max3(COOLDOWN_CYCLES, RELOAD_CYCLES, DEBOUNCE_CYCLES) + 1);

  logic fire_stb, reload_stb;

`ifdef FIRING_DEBOUNCE_EN
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire_cond (
    .clk(clk), .reset(reset), .btn(fire_btn), .press(fire_stb)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reload_cond (
    .clk(clk), .reset(reset), .btn(reload_btn), .press(reload_stb)
  );
`else
  button_conditioner u_fire_cond (
    .clk(clk), .reset(reset), .btn(fire_btn), .press(fire_stb)
  );
  button_conditioner u_reload_cond (
    .clk(clk), .reset(reset), .btn(reload_btn), .press(reload_stb)
  );
`endif

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         control_q, control_d;
  logic               shot_fired_q, shot_fired_d;
  logic               dry_fire_q, dry_fire_d;
  logic               reloading_q, reloading_d;

  logic fire_go, reload_go;

  assign fire_go   = round_active & fire_stb;
  assign reload_go = round_active & reload_stb;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    dry_fire_d = 1'b0;

    unique case (state_q)
      S_HOLD: begin
        if (fire_go && remaining_shots != 2'd0)
          state_d = S_FIRE;
        else if (reload_go && remaining_shots != MAX_SHOTS)
          state_d = S_RELOAD;
        else if (fire_go)
          dry_fire_d = 1'b1;
      end
      S_FIRE:   state_d = S_COOL;
      S_COOL:   if (timer_q == TIMER_W'(COOLDOWN_CYCLES - 1)) state_d = S_HOLD;
      S_RELOAD: if (timer_q == TIMER_W'(RELOAD_CYCLES - 1))   state_d = S_HOLD;
      default:  state_d = S_HOLD;
    endcase

    if (!round_active) state_d = S_HOLD;

    // Restart the timer on every state change; it only advances while timing.
    if (state_d != state_q || state_q == S_HOLD || state_q == S_FIRE)
      timer_d = '0;
    else
      timer_d = timer_q + 1'b1;
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_comb begin
    control_d    = CTRL_HOLD;
    shot_fired_d = 1'b0;
    reloading_d  = 1'b0;
    unique case (state_d)
      S_FIRE: begin
        control_d    = CTRL_SHOT;
        shot_fired_d = 1'b1;
      end
      S_RELOAD: begin
        control_d   = CTRL_RELOAD;
        reloading_d = 1'b1;
      end
      default: control_d = CTRL_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_HOLD;
      timer_q      <= '0;
      control_q    <= CTRL_HOLD;
      shot_fired_q <= 1'b0;
      dry_fire_q   <= 1'b0;
      reloading_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      control_q    <= control_d;
      shot_fired_q <= shot_fired_d;
      dry_fire_q   <= dry_fire_d;
      reloading_q  <= reloading_d;
    end
  end

  assign control    = control_q;
  assign shot_fired = shot_fired_q;
  assign dry_fire   = dry_fire_q;
  assign reloading  = reloading_q;

endmodule

// File: tb/tb_firing_controller.sv
// Self-checking bench for firing_controller: randomized button traffic checked
// against a plan-queue model of the trigger/reload behaviour.
module tb_firing_controller;
  import firing_pkg::*;

  localparam int C = 4;
  localparam int R = 8;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       fire_btn, reload_btn, round_active;
  logic [1:0] remaining_shots;
  logic [2:0] control;
  logic       shot_fired, dry_fire, reloading;

  int checks   = 0;
  int failures = 0;

  firing_controller #(
    .COOLDOWN_CYCLES(C), .RELOAD_CYCLES(R), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .reset(reset), .fire_btn(fire_btn), .reload_btn(reload_btn),
    .round_active(round_active), .remaining_shots(remaining_shots),
    .control(control), .shot_fired(shot_fired), .dry_fire(dry_fire),
    .reloading(reloading)
  );

  always #5 clk = ~clk;

  // Reference model: button sample history and a queue of already-committed
  // control codes. While the queue drains, new presses are ignored.
  bit [2:0]   f_hist, r_hist;
  logic [2:0] plan[$];
  logic [2:0] exp_ctrl;
  logic       exp_dry;
  bit         dp_en;

  function automatic logic [5:0] observed();
    return {control, shot_fired, dry_fire, reloading};
  endfunction

  function automatic logic [5:0] expected();
    return {exp_ctrl, exp_ctrl == CTRL_SHOT, exp_dry, exp_ctrl == CTRL_RELOAD};
  endfunction

  task automatic model_reset();
    f_hist = '0; r_hist = '0;
    plan.delete();
    exp_ctrl = CTRL_HOLD;
    exp_dry  = 1'b0;
  endtask

  task automatic model_edge();
    bit pf, pr;
    pf = f_hist[1] && !f_hist[2];
    pr = r_hist[1] && !r_hist[2];
    f_hist = {f_hist[1:0], fire_btn};
    r_hist = {r_hist[1:0], reload_btn};
    exp_dry = 1'b0;
    if (!round_active) begin
      plan.delete();
      exp_ctrl = CTRL_HOLD;
    end else if (plan.size() > 0) begin
      exp_ctrl = plan.pop_front();
    end else if (pf && remaining_shots != 2'd0) begin
      exp_ctrl = CTRL_SHOT;
      repeat (C + 1) plan.push_back(CTRL_HOLD);
    end else if (pr && remaining_shots != 2'd3) begin
      exp_ctrl = CTRL_RELOAD;
      repeat (R - 1) plan.push_back(CTRL_RELOAD);
      plan.push_back(CTRL_HOLD);
    end else begin
      exp_ctrl = CTRL_HOLD;
      exp_dry  = pf;
    end
  endtask

  // One clock: model follows the active edge, outputs are then stable at the
  // falling edge; the datapath stand-in updates the shot count there.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (dp_en) begin
      if (exp_ctrl == CTRL_SHOT && remaining_shots != 2'd0) remaining_shots = remaining_shots - 2'd1;
      else if (exp_ctrl == CTRL_RELOAD) remaining_shots = 2'd3;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fire_btn = 1'b0; reload_btn = 1'b0;
    round_active = 1'b1; remaining_shots = 2'd3; dp_en = 1'b0;
    model_reset();
    #1;
    checks++;
    if (observed() !== {CTRL_HOLD, 3'b000}) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", observed(), {CTRL_HOLD, 3'b000});
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
    end
  endtask

  task automatic test_fire_hold();
    int shots;
    int first;
    shots = 0; first = -1;
    remaining_shots = 2'd3;
    for (int i = 1; i <= 20; i++) begin
      fire_btn = (i <= 10);
      tick();
      checks++;
      if (observed() !== expected()) begin
        failures++;
        $display("FAIL fire_hold cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
      if (control === CTRL_SHOT) begin
        shots++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (shots != 1 || first != 3) begin
      failures++;
      $display("FAIL fire_hold_count shots=%0d first_edge=%0d exp shots=1 first_edge=3", shots, first);
    end
  endtask

  task automatic test_deplete();
    int shots, drys;
    shots = 0; drys = 0;
    dp_en = 1'b1;
    remaining_shots = 2'd3;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 20; i++) begin
        fire_btn = (i < 3);
        tick();
        checks++;
        if (observed() !== expected()) begin
          failures++;
          $display("FAIL deplete press=%0d cyc=%0d got=%b exp=%b", p, i, observed(), expected());
        end
        if (shot_fired === 1'b1) shots++;
        if (dry_fire === 1'b1) drys++;
      end
    end
    dp_en = 1'b0;
    checks++;
    if (shots != 3 || drys != 1) begin
      failures++;
      $display("FAIL deplete_count shots=%0d dry=%0d exp shots=3 dry=1", shots, drys);
    end
  endtask

  task automatic test_reload();
    int rl, shots;
    rl = 0; shots = 0;
    remaining_shots = 2'd0;
    for (int i = 0; i < 20; i++) begin
      reload_btn = (i < 2);
      fire_btn   = (i >= 4 && i < 6) || (i >= 8 && i < 9);
      tick();
      checks++;
      if (observed() !== expected()) begin
        failures++;
        $display("FAIL reload cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
      if (reloading === 1'b1) rl++;
      if (shot_fired === 1'b1) shots++;
    end
    checks++;
    if (rl != R || shots != 0) begin
      failures++;
      $display("FAIL reload_len reload_cycles=%0d shots=%0d exp %0d and 0", rl, shots, R);
    end
  endtask

  task automatic test_simultaneous();
    int shots, rl, drys;
    for (int pass = 0; pass < 2; pass++) begin
      shots = 0; rl = 0; drys = 0;
      remaining_shots = (pass == 0) ? 2'd2 : 2'd0;
      for (int i = 0; i < 20; i++) begin
        fire_btn   = (i < 3);
        reload_btn = (i < 3);
        tick();
        checks++;
        if (observed() !== expected()) begin
          failures++;
          $display("FAIL simultaneous pass=%0d cyc=%0d got=%b exp=%b", pass, i, observed(), expected());
        end
        if (shot_fired === 1'b1) shots++;
        if (reloading === 1'b1) rl++;
        if (dry_fire === 1'b1) drys++;
      end
      checks++;
      if ((pass == 0 && (shots != 1 || rl != 0)) || (pass == 1 && (shots != 0 || rl != R || drys != 0))) begin
        failures++;
        $display("FAIL simultaneous_winner pass=%0d shots=%0d reload=%0d dry=%0d", pass, shots, rl, drys);
      end
    end
  endtask

  task automatic test_round_abort();
    int rl;
    rl = 0;
    remaining_shots = 2'd1;
    for (int i = 1; i <= 24; i++) begin
      reload_btn   = (i <= 2);
      round_active = !(i >= 6 && i <= 12);
      fire_btn     = (i >= 8 && i <= 9);
      tick();
      checks++;
      if (observed() !== expected()) begin
        failures++;
        $display("FAIL round_abort cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
      if (reloading === 1'b1) rl++;
    end
    round_active = 1'b1;
    checks++;
    if (rl != 3) begin
      failures++;
      $display("FAIL round_abort_len reload_cycles=%0d exp=3", rl);
    end
  endtask

  task automatic test_reset_mid();
    for (int kind = 0; kind < 2; kind++) begin
      remaining_shots = 2'd1;
      fire_btn   = (kind == 0);
      reload_btn = (kind == 1);
      repeat (4) tick();
      fire_btn = 1'b0; reload_btn = 1'b0;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (observed() !== {CTRL_HOLD, 3'b000}) begin
        failures++;
        $display("FAIL reset_mid kind=%0d got=%b exp=%b", kind, observed(), {CTRL_HOLD, 3'b000});
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick();
        checks++;
        if (observed() !== expected()) begin
          failures++;
          $display("FAIL reset_mid_after kind=%0d cyc=%0d got=%b exp=%b", kind, i, observed(), expected());
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0)  fire_btn   = ~fire_btn;
      if ($urandom_range(8) == 0)  reload_btn = ~reload_btn;
      round_active = ($urandom_range(30) != 0);
      if ($urandom_range(20) == 0) remaining_shots = 2'($urandom_range(3));
      tick();
      checks++;
      if (observed() !== expected()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
    end
    fire_btn = 1'b0; reload_btn = 1'b0; round_active = 1'b1;
  endtask

  task automatic test_debounce();
    int shots, first;
    remaining_shots = 2'd3;
    fire_btn = 1'b0; reload_btn = 1'b0;
    repeat (40) @(negedge clk);
    shots = 0;
    for (int i = 1; i <= 50; i++) begin
      fire_btn = (i <= 10);
      @(negedge clk);
      if (shot_fired === 1'b1) shots++;
    end
    checks++;
    if (shots != 0) begin
      failures++;
      $display("FAIL debounce_glitch shots=%0d exp=0", shots);
    end
    first = -1;
    for (int i = 1; i <= 60; i++) begin
      fire_btn = (i <= 20);
      @(negedge clk);
      if (control === CTRL_SHOT && first < 0) first = i;
    end
    checks++;
    if (first != D + 3) begin
      failures++;
      $display("FAIL debounce_latency shot_edge=%0d exp=%0d", first, D + 3);
    end
  endtask

  initial begin
    test_reset();
`ifdef FIRING_DEBOUNCE_EN
    test_debounce();
`else
    test_fire_hold();
    test_deplete();
    test_reload();
    test_simultaneous();
    test_round_abort();
    test_reset_mid();
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
